// File: rtl/cmd_frame_pkg.sv
// Shared definitions for the command-frame controller: opcode values,
// the controller/serializer state encoding and small decode helpers.
package cmd_frame_pkg;

    localparam logic [7:0] OP_WRITE     = 8'hAA;
    localparam logic [7:0] OP_READ      = 8'hBB;
    localparam logic [7:0] OP_ALU_OPS   = 8'hCC;
    localparam logic [7:0] OP_ALU_NOOPS = 8'hDD;
    localparam logic [7:0] OP_BURST     = 8'hEE;

    // One encoding is shared by the frame FSM and the TX serializer so both
    // can be read against the same state names; IDLE doubles as the
    // serializer's "nothing to send" state.
    typedef enum logic [3:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        GET_CNT,
        GET_A,
        GET_B,
        GET_FUN,
        RD_WAIT,
        ALU_WAIT,
        TX_LOAD,
        TX_WAIT_HI,
        TX_WAIT_LO
    } state_e;

    // Which command owns the frame; the address/data states are shared
    // between write, read and burst, so the frame FSM needs to remember it.
    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_WRITE,
        CMD_READ,
        CMD_BURST
    } cmd_e;

    // True in every state that is waiting for another RX word of a frame.
    function automatic logic isGetState(input state_e s);
        logic result;
        case (s)
            GET_ADDR, GET_DATA, GET_CNT, GET_A, GET_B, GET_FUN: result = 1'b1;
            default:                                            result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/cmd_tx_seq.sv
// TX word serializer: sends one or two DATA_WIDTH words (low word first)
// using the TX_Valid / Busy handshake, then reports completion.
module cmd_tx_seq
    import cmd_frame_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      start_i,
    input  logic [2*DATA_WIDTH-1:0]   word_i,
    input  logic                      twoWords_i,
    input  logic                      busy_i,
    output logic [DATA_WIDTH-1:0]     pData_o,
    output logic                      valid_o,
    output logic                      done_o
);

    state_e                    state_q, state_d;
    logic [2*DATA_WIDTH-1:0]   buf_q, buf_d;
    logic                      twoWords_q, twoWords_d;
    logic                      wordIdx_q, wordIdx_d;

    // Handshake sequencing: load the payload on start, present a word while
    // the transmitter is free, then wait for its busy pulse to rise and fall
    // before moving to the next word or signalling completion.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        twoWords_d = twoWords_q;
        wordIdx_d  = wordIdx_q;
        pData_o    = '0;
        valid_o    = 1'b0;
        done_o     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    buf_d      = word_i;
                    twoWords_d = twoWords_i;
                    wordIdx_d  = 1'b0;
                    state_d    = TX_LOAD;
                end
            end
            TX_LOAD: begin
                if (!busy_i) begin
                    valid_o = 1'b1;
                    pData_o = wordIdx_q ? buf_q[2*DATA_WIDTH-1:DATA_WIDTH]
                                        : buf_q[DATA_WIDTH-1:0];
                    state_d = TX_WAIT_HI;
                end
            end
            TX_WAIT_HI: begin
                if (busy_i) begin
                    state_d = TX_WAIT_LO;
                end
            end
            TX_WAIT_LO: begin
                if (!busy_i) begin
                    if (twoWords_q && !wordIdx_q) begin
                        wordIdx_d = 1'b1;
                        state_d   = TX_LOAD;
                    end else begin
                        done_o  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Serializer state and payload registers, cleared by reset even mid-word.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            twoWords_q <= 1'b0;
            wordIdx_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            twoWords_q <= twoWords_d;
            wordIdx_q  <= wordIdx_d;
        end
    end

endmodule

// File: rtl/cmd_frame_ctrl.sv
// Command-frame controller: decodes RX command frames, drives the register
// file and ALU, and hands read/ALU results to the TX serializer.
// Optional feature: define CMD_TIMEOUT_EN to abort a frame (Err pulse,
// back to IDLE) after TIMEOUT_CYCLES cycles without an RX word.
module cmd_frame_ctrl
    import cmd_frame_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int FUN_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      CmdCtrl_CLK,
    input  logic                      CmdCtrl_RST,
    input  logic [DATA_WIDTH-1:0]     CmdCtrl_RX_PData,
    input  logic                      CmdCtrl_RX_Valid,
    input  logic [DATA_WIDTH-1:0]     CmdCtrl_RdData,
    input  logic                      CmdCtrl_RdData_Valid,
    input  logic [2*DATA_WIDTH-1:0]   CmdCtrl_ALU_Out,
    input  logic                      CmdCtrl_ALU_Valid,
    input  logic                      CmdCtrl_Busy,
    output logic [DATA_WIDTH-1:0]     CmdCtrl_TX_PData,
    output logic                      CmdCtrl_TX_Valid,
    output logic [DATA_WIDTH-1:0]     CmdCtrl_WrData,
    output logic [ADDR_WIDTH-1:0]     CmdCtrl_Addr,
    output logic                      CmdCtrl_Wr_en,
    output logic                      CmdCtrl_Rd_en,
    output logic [FUN_WIDTH-1:0]      CmdCtrl_ALU_Fun,
    output logic                      CmdCtrl_ALU_en,
    output logic                      CmdCtrl_CLK_en,
    output logic                      CmdCtrl_CLK_div_en,
    output logic                      CmdCtrl_Err
);

    // Burst count is one bit wider so that N = 0 can stand for 2^DATA_WIDTH.
    localparam logic [DATA_WIDTH:0] BURST_FULL = {1'b1, {DATA_WIDTH{1'b0}}};
    localparam logic [DATA_WIDTH:0] BURST_LAST = (DATA_WIDTH+1)'(1);

    state_e                    state_q, state_d;
    cmd_e                      cmd_q, cmd_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]     nextAddr_q, nextAddr_d;
    logic [DATA_WIDTH-1:0]     wrData_q, wrData_d;
    logic [DATA_WIDTH:0]       burstCnt_q, burstCnt_d;
    logic [FUN_WIDTH-1:0]      fun_q, fun_d;
    logic                      wrEn_q, wrEn_d;
    logic                      rdEn_q, rdEn_d;
    logic                      aluEn_q, aluEn_d;
    logic                      clkEn_q, clkEn_d;
    logic                      err_q, err_d;

    logic                      txStart;
    logic [2*DATA_WIDTH-1:0]   txWord;
    logic                      txTwoWords;
    logic                      txDone;
    logic                      timeoutHit;

    logic [7:0]                rxOpcode;
    logic [ADDR_WIDTH-1:0]     rxAddr;

    assign rxOpcode = CmdCtrl_RX_PData[7:0];
    assign rxAddr   = CmdCtrl_RX_PData[ADDR_WIDTH-1:0];

`ifdef CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idleCnt_q, idleCnt_d;

    // Count silent cycles while a frame is half-received; any RX word or
    // leaving the GET_* states restarts the count.
    always_comb begin
        idleCnt_d  = '0;
        timeoutHit = 1'b0;
        if (isGetState(state_q) && !CmdCtrl_RX_Valid) begin
            idleCnt_d = idleCnt_q + 1'b1;
            if (idleCnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                timeoutHit = 1'b1;
                idleCnt_d  = '0;
            end
        end
    end

    // Silent-cycle counter register.
    always_ff @(posedge CmdCtrl_CLK) begin
        if (CmdCtrl_RST) begin
            idleCnt_q <= '0;
        end else begin
            idleCnt_q <= idleCnt_d;
        end
    end
`else
    assign timeoutHit = 1'b0;
`endif

    // Frame decoding: one state step per accepted RX word; strobes are
    // registered so each fires in the cycle after the word that caused it.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        nextAddr_d = nextAddr_q;
        wrData_d   = wrData_q;
        burstCnt_d = burstCnt_q;
        fun_d      = fun_q;
        wrEn_d     = 1'b0;
        rdEn_d     = 1'b0;
        aluEn_d    = 1'b0;
        err_d      = 1'b0;
        clkEn_d    = clkEn_q;
        txStart    = 1'b0;
        txWord     = '0;
        txTwoWords = 1'b0;
        case (state_q)
            IDLE: begin
                if (CmdCtrl_RX_Valid) begin
                    case (rxOpcode)
                        OP_WRITE: begin
                            cmd_d   = CMD_WRITE;
                            state_d = GET_ADDR;
                        end
                        OP_READ: begin
                            cmd_d   = CMD_READ;
                            state_d = GET_ADDR;
                        end
                        OP_BURST: begin
                            cmd_d   = CMD_BURST;
                            state_d = GET_ADDR;
                        end
                        OP_ALU_OPS: begin
                            cmd_d   = CMD_NONE;
                            state_d = GET_A;
                        end
                        OP_ALU_NOOPS: begin
                            cmd_d   = CMD_NONE;
                            state_d = GET_FUN;
                        end
                        default: begin
                            cmd_d = CMD_NONE;
                            err_d = 1'b1;
                        end
                    endcase
                end
            end
            GET_ADDR: begin
                if (CmdCtrl_RX_Valid) begin
                    nextAddr_d = rxAddr;
                    case (cmd_q)
                        CMD_READ: begin
                            addr_d  = rxAddr;
                            rdEn_d  = 1'b1;
                            state_d = RD_WAIT;
                        end
                        CMD_BURST: state_d = GET_CNT;
                        default:   state_d = GET_DATA;
                    endcase
                end
            end
            GET_CNT: begin
                if (CmdCtrl_RX_Valid) begin
                    burstCnt_d = (CmdCtrl_RX_PData == '0) ? BURST_FULL
                                                          : {1'b0, CmdCtrl_RX_PData};
                    state_d    = GET_DATA;
                end
            end
            GET_DATA: begin
                if (CmdCtrl_RX_Valid) begin
                    addr_d   = nextAddr_q;
                    wrData_d = CmdCtrl_RX_PData;
                    wrEn_d   = 1'b1;
                    if (cmd_q == CMD_BURST) begin
                        nextAddr_d = nextAddr_q + 1'b1;
                        burstCnt_d = burstCnt_q - 1'b1;
                        if (burstCnt_q == BURST_LAST) begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GET_A: begin
                if (CmdCtrl_RX_Valid) begin
                    addr_d   = '0;
                    wrData_d = CmdCtrl_RX_PData;
                    wrEn_d   = 1'b1;
                    state_d  = GET_B;
                end
            end
            GET_B: begin
                if (CmdCtrl_RX_Valid) begin
                    addr_d   = ADDR_WIDTH'(1);
                    wrData_d = CmdCtrl_RX_PData;
                    wrEn_d   = 1'b1;
                    state_d  = GET_FUN;
                end
            end
            GET_FUN: begin
                if (CmdCtrl_RX_Valid) begin
                    fun_d   = CmdCtrl_RX_PData[FUN_WIDTH-1:0];
                    aluEn_d = 1'b1;
                    clkEn_d = 1'b1;
                    state_d = ALU_WAIT;
                end
            end
            RD_WAIT: begin
                if (CmdCtrl_RdData_Valid) begin
                    txStart    = 1'b1;
                    txWord     = {{DATA_WIDTH{1'b0}}, CmdCtrl_RdData};
                    txTwoWords = 1'b0;
                    state_d    = TX_LOAD;
                end
            end
            ALU_WAIT: begin
                if (CmdCtrl_ALU_Valid) begin
                    clkEn_d    = 1'b0;
                    txStart    = 1'b1;
                    txWord     = CmdCtrl_ALU_Out;
                    txTwoWords = 1'b1;
                    state_d    = TX_LOAD;
                end
            end
            // The serializer owns the detailed TX handshake; the frame FSM
            // parks here (ignoring RX) until it reports the last word sent.
            TX_LOAD: begin
                if (txDone) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (timeoutHit) begin
            state_d = IDLE;
            cmd_d   = CMD_NONE;
            err_d   = 1'b1;
        end
    end

    // Frame state, holding registers and registered strobes; reset clears
    // everything so a frame or transmission in flight is abandoned.
    always_ff @(posedge CmdCtrl_CLK) begin
        if (CmdCtrl_RST) begin
            state_q    <= IDLE;
            cmd_q      <= CMD_NONE;
            addr_q     <= '0;
            nextAddr_q <= '0;
            wrData_q   <= '0;
            burstCnt_q <= '0;
            fun_q      <= '0;
            wrEn_q     <= 1'b0;
            rdEn_q     <= 1'b0;
            aluEn_q    <= 1'b0;
            clkEn_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            nextAddr_q <= nextAddr_d;
            wrData_q   <= wrData_d;
            burstCnt_q <= burstCnt_d;
            fun_q      <= fun_d;
            wrEn_q     <= wrEn_d;
            rdEn_q     <= rdEn_d;
            aluEn_q    <= aluEn_d;
            clkEn_q    <= clkEn_d;
            err_q      <= err_d;
        end
    end

    cmd_tx_seq #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_txSeq (
        .clock_i    (CmdCtrl_CLK),
        .reset_i    (CmdCtrl_RST),
        .start_i    (txStart),
        .word_i     (txWord),
        .twoWords_i (txTwoWords),
        .busy_i     (CmdCtrl_Busy),
        .pData_o    (CmdCtrl_TX_PData),
        .valid_o    (CmdCtrl_TX_Valid),
        .done_o     (txDone)
    );

    assign CmdCtrl_WrData     = wrData_q;
    assign CmdCtrl_Addr       = addr_q;
    assign CmdCtrl_Wr_en      = wrEn_q;
    assign CmdCtrl_Rd_en      = rdEn_q;
    assign CmdCtrl_ALU_Fun    = fun_q;
    assign CmdCtrl_ALU_en     = aluEn_q;
    assign CmdCtrl_CLK_en     = clkEn_q;
    assign CmdCtrl_Err        = err_q;
    assign CmdCtrl_CLK_div_en = 1'b1;

endmodule

// File: tb/tb_cmd_frame_ctrl.sv
// Self-checking bench for cmd_frame_ctrl: directed frames, with expected
// register writes, reads, ALU starts, TX words and errors queued as stimulus
// is driven and compared as the design produces them.
module tb_cmd_frame_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int FW = 4;
    localparam int TO = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   rxPData;
    logic            rxValid;
    logic [DW-1:0]   rdData;
    logic            rdDataValid;
    logic [2*DW-1:0] aluOut;
    logic            aluValid;
    logic            busy;
    logic [DW-1:0]   txPData;
    logic            txValid;
    logic [DW-1:0]   wrData;
    logic [AW-1:0]   addr;
    logic            wrEn;
    logic            rdEn;
    logic [FW-1:0]   aluFun;
    logic            aluEn;
    logic            clkEn;
    logic            clkDivEn;
    logic            err;

    int checks = 0;
    int errors = 0;

    logic [AW+DW-1:0] wrQ[$];
    logic [AW-1:0]    rdQ[$];
    logic [DW-1:0]    txQ[$];
    logic [FW-1:0]    funQ[$];
    int               errPending = 0;

    logic            holdBusyLow = 1'b0;
    logic [DW-1:0]   rdValue = '0;
    logic [2*DW-1:0] aluResult = '0;
    logic [FW-1:0]   curFun = '0;

    cmd_frame_ctrl #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .FUN_WIDTH      (FW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CmdCtrl_CLK          (clk),
        .CmdCtrl_RST          (rst),
        .CmdCtrl_RX_PData     (rxPData),
        .CmdCtrl_RX_Valid     (rxValid),
        .CmdCtrl_RdData       (rdData),
        .CmdCtrl_RdData_Valid (rdDataValid),
        .CmdCtrl_ALU_Out      (aluOut),
        .CmdCtrl_ALU_Valid    (aluValid),
        .CmdCtrl_Busy         (busy),
        .CmdCtrl_TX_PData     (txPData),
        .CmdCtrl_TX_Valid     (txValid),
        .CmdCtrl_WrData       (wrData),
        .CmdCtrl_Addr         (addr),
        .CmdCtrl_Wr_en        (wrEn),
        .CmdCtrl_Rd_en        (rdEn),
        .CmdCtrl_ALU_Fun      (aluFun),
        .CmdCtrl_ALU_en       (aluEn),
        .CmdCtrl_CLK_en       (clkEn),
        .CmdCtrl_CLK_div_en   (clkDivEn),
        .CmdCtrl_Err          (err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One RX word as a single-cycle strobe.
    task automatic applyStimulus(input logic [DW-1:0] word);
        @(posedge clk);
        #1 rxPData = word;
        rxValid = 1'b1;
        @(posedge clk);
        #1 rxValid = 1'b0;
        rxPData = '0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput(tag, {txValid, txPData, wrData, addr, wrEn, rdEn, aluFun,
                          aluEn, clkEn, err, clkDivEn}, 64'd1);
    endtask

    // Scoreboard: every strobe from the design must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (wrEn) begin
                checkOutput("wr_expected", 64'(wrQ.size() != 0), 64'd1);
                if (wrQ.size() != 0) checkOutput("wr_addr_data", {addr, wrData}, wrQ.pop_front());
            end
            if (rdEn) begin
                checkOutput("rd_expected", 64'(rdQ.size() != 0), 64'd1);
                if (rdQ.size() != 0) checkOutput("rd_addr", addr, rdQ.pop_front());
            end
            if (txValid) begin
                checkOutput("tx_expected", 64'(txQ.size() != 0), 64'd1);
                if (txQ.size() != 0) checkOutput("tx_word", txPData, txQ.pop_front());
            end
            if (aluEn) begin
                checkOutput("alu_expected", 64'(funQ.size() != 0), 64'd1);
                if (funQ.size() != 0) checkOutput("alu_fun_at_start", aluFun, funQ.pop_front());
                checkOutput("clk_en_at_start", clkEn, 1);
            end
            if (aluValid) begin
                checkOutput("alu_fun_stable", aluFun, curFun);
                checkOutput("clk_en_until_valid", clkEn, 1);
            end
            if (err) begin
                checkOutput("err_expected", 64'(errPending > 0), 64'd1);
                if (errPending > 0) errPending--;
            end
        end
    end

    // Transmitter model: raises Busy after each TX word, unless told to stall.
    initial begin
        busy = 1'b0;
        forever begin
            @(negedge clk);
            if (txValid && !rst && !holdBusyLow) begin
                @(posedge clk);
                #1 busy = 1'b1;
                repeat (3) @(posedge clk);
                #1 busy = 1'b0;
            end
        end
    end

    // Register-file model: returns rdValue one cycle after a read strobe.
    initial begin
        rdData      = '0;
        rdDataValid = 1'b0;
        forever begin
            @(negedge clk);
            if (rdEn && !rst) begin
                @(posedge clk);
                #1 rdData = rdValue;
                rdDataValid = 1'b1;
                @(posedge clk);
                #1 rdDataValid = 1'b0;
            end
        end
    end

    // ALU model: returns aluResult a few cycles after the start strobe.
    initial begin
        aluOut   = '0;
        aluValid = 1'b0;
        forever begin
            @(negedge clk);
            if (aluEn && !rst) begin
                repeat (3) @(posedge clk);
                #1 aluOut = aluResult;
                aluValid = 1'b1;
                @(posedge clk);
                #1 aluValid = 1'b0;
            end
        end
    end

    // Directed sequence of frames.
    initial begin
        rst     = 1'b1;
        rxPData = '0;
        rxValid = 1'b0;
        waitCycles(3);
        checkResetOutputs("reset_state");
        rst = 1'b0;
        waitCycles(2);

        $display("[TB] write frame");
        wrQ.push_back({4'h5, 8'h3C});
        applyStimulus(8'hAA);
        applyStimulus(8'h05);
        applyStimulus(8'h3C);
        waitCycles(6);

        $display("[TB] read frame");
        rdQ.push_back(4'h2);
        rdValue = 8'h7E;
        txQ.push_back(8'h7E);
        applyStimulus(8'hBB);
        applyStimulus(8'h02);
        waitCycles(20);

        $display("[TB] ALU frame with operands");
        wrQ.push_back({4'h0, 8'h10});
        wrQ.push_back({4'h1, 8'h03});
        funQ.push_back(4'h2);
        curFun    = 4'h2;
        aluResult = 16'h0030;
        txQ.push_back(8'h30);
        txQ.push_back(8'h00);
        applyStimulus(8'hCC);
        applyStimulus(8'h10);
        applyStimulus(8'h03);
        applyStimulus(8'h02);
        waitCycles(40);
        checkOutput("clk_en_after_alu", clkEn, 0);
        checkOutput("alu_fun_held", aluFun, 4'h2);

        $display("[TB] ALU frame without operands");
        funQ.push_back(4'h5);
        curFun    = 4'h5;
        aluResult = 16'hBEEF;
        txQ.push_back(8'hEF);
        txQ.push_back(8'hBE);
        applyStimulus(8'hDD);
        applyStimulus(8'h05);
        waitCycles(40);

        $display("[TB] burst with address wrap");
        wrQ.push_back({4'hE, 8'h11});
        wrQ.push_back({4'hF, 8'h22});
        wrQ.push_back({4'h0, 8'h33});
        applyStimulus(8'hEE);
        applyStimulus(8'h0E);
        applyStimulus(8'h03);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        applyStimulus(8'h33);
        waitCycles(5);

        $display("[TB] burst with count 0");
        applyStimulus(8'hEE);
        applyStimulus(8'h08);
        applyStimulus(8'h00);
        for (int i = 0; i < 256; i++) begin
            wrQ.push_back({AW'(8 + i), DW'(i)});
            applyStimulus(DW'(i));
        end
        wrQ.push_back({4'h9, 8'h77});
        applyStimulus(8'hAA);
        applyStimulus(8'h09);
        applyStimulus(8'h77);
        waitCycles(5);
        checkOutput("burst_zero_drained", wrQ.size(), 0);

        $display("[TB] unknown opcode");
        errPending++;
        applyStimulus(8'h55);
        waitCycles(3);
        checkOutput("err_after_unknown", errPending, 0);
        wrQ.push_back({4'h1, 8'h01});
        applyStimulus(8'hAA);
        applyStimulus(8'h01);
        applyStimulus(8'h01);
        waitCycles(5);

        $display("[TB] reset during TX wait");
        holdBusyLow = 1'b1;
        rdQ.push_back(4'h3);
        rdValue = 8'h5A;
        txQ.push_back(8'h5A);
        applyStimulus(8'hBB);
        applyStimulus(8'h03);
        waitCycles(10);
        checkOutput("tx_valid_in_wait_hi", txValid, 0);
        checkOutput("tx_sent_before_reset", txQ.size(), 0);
        rst = 1'b1;
        waitCycles(2);
        checkResetOutputs("reset_mid_tx");
        rst = 1'b0;
        holdBusyLow = 1'b0;
        waitCycles(2);
        rdQ.push_back(4'h4);
        rdValue = 8'hA5;
        txQ.push_back(8'hA5);
        applyStimulus(8'hBB);
        applyStimulus(8'h04);
        waitCycles(20);

`ifdef CMD_TIMEOUT_EN
        $display("[TB] inter-word timeout");
        errPending++;
        applyStimulus(8'hAA);
        waitCycles(TO - 4);
        checkOutput("timeout_not_early", errPending, 1);
        waitCycles(10);
        checkOutput("timeout_err", errPending, 0);
        wrQ.push_back({4'h6, 8'h44});
        applyStimulus(8'hAA);
        applyStimulus(8'h06);
        applyStimulus(8'h44);
        waitCycles(5);
`else
        $display("[TB] long gap without timeout");
        applyStimulus(8'hAA);
        waitCycles(TO + 10);
        checkOutput("no_timeout_err", errPending, 0);
        wrQ.push_back({4'h6, 8'h44});
        applyStimulus(8'h06);
        applyStimulus(8'h44);
        waitCycles(5);
`endif

        waitCycles(10);
        checkOutput("wr_queue_empty", wrQ.size(), 0);
        checkOutput("rd_queue_empty", rdQ.size(), 0);
        checkOutput("tx_queue_empty", txQ.size(), 0);
        checkOutput("alu_queue_empty", funQ.size(), 0);
        checkOutput("err_pending_zero", errPending, 0);
        checkOutput("clk_div_en_high", clkDivEn, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
